memory_cycle: RTL

MEMORY_CYCLE -- requirements
Module: memory_cycle

---
 rtl/pipe_pkg.sv | 32 +++
 rtl/memory_cycle_data_memory.sv | 26 ++
 rtl/memory_cycle.sv | 130 +++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions for the memory stage: FSM encoding, bubble values
// and the writeback register payload.
package pipe_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned REG_W  = 5;
    localparam int unsigned CNT_W  = 4;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } memState_t;

    // Control values loaded into the W register when the access has not completed.
    localparam logic             BUBBLE_REG_WRITE  = 1'b0;
    localparam logic             BUBBLE_RESULT_SRC = 1'b0;
    localparam logic [REG_W-1:0] BUBBLE_RD         = REG_W'(0);

    typedef struct packed {
        logic              regWrite;
        logic              resultSrc;
        logic [REG_W-1:0]  rd;
        logic [DATA_W-1:0] aluResult;
        logic [DATA_W-1:0] readData;
        logic [DATA_W-1:0] pcPlus4;
    } wbRegs_t;

    function automatic logic isMemOp(input logic memWrite, input logic resultSrc);
        return memWrite | resultSrc;
    endfunction

endpackage

// File: rtl/memory_cycle_data_memory.sv
// Word-addressed data array: combinational read, write on the clock edge when we=1.
// Contents are deliberately not reset.
module data_memory
    import pipe_pkg::*;
#(
    parameter int unsigned DEPTH  = 64,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wd,
    output logic [DATA_W-1:0] rd
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wd;
        end
    end

    assign rd = mem[addr];

endmodule

// File: rtl/memory_cycle.sv
// Pipeline memory stage with the M->W register. Define DMEM_WAIT_STATES_EN to add
// an IDLE/WAIT stall FSM that stretches each memory op to WAIT_CYCLES+1 cycles.
module memory_cycle
    import pipe_pkg::*;
#(
    parameter int unsigned DEPTH       = 64,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              RegWriteM,
    input  logic              MemWriteM,
    input  logic              ResultSrcM,
    input  logic [REG_W-1:0]  RDM,
    input  logic [DATA_W-1:0] ALUResultM,
    input  logic [DATA_W-1:0] WriteDataM,
    input  logic [DATA_W-1:0] PCPlus4M,
    output logic              RegWriteW,
    output logic              ResultSrcW,
    output logic [REG_W-1:0]  RDW,
    output logic [DATA_W-1:0] ALUResultW,
    output logic [DATA_W-1:0] ReadDataW,
    output logic [DATA_W-1:0] PCPlus4W,
    output logic [DATA_W-1:0] ResultW,
    output logic              StallM
);

    localparam int unsigned ADDR_W = $clog2(DEPTH);

    logic [ADDR_W-1:0] wordAddr;
    logic [DATA_W-1:0] readData;
    logic              stallC;
    logic              complete;
    logic              memWe;
    wbRegs_t           wb;

    // Byte offset and bits above the array size are dropped, so addresses wrap.
    assign wordAddr = ALUResultM[ADDR_W+1:2];

    logic unusedAddrBits;
    assign unusedAddrBits = ^{ALUResultM[DATA_W-1:ADDR_W+2], ALUResultM[1:0]};

`ifdef DMEM_WAIT_STATES_EN
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WAIT_CYCLES - 1);

    memState_t        state;
    logic [CNT_W-1:0] cnt;
    logic             memOp;

    assign memOp = isMemOp(MemWriteM, ResultSrcM);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= CNT_W'(0);
        end else begin
            case (state)
                IDLE: begin
                    if (memOp) begin
                        state <= WAIT;
                        cnt   <= CNT_W'(0);
                    end
                end
                WAIT: begin
                    if (cnt == LAST_CNT) begin
                        state <= IDLE;
                        cnt   <= CNT_W'(0);
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= CNT_W'(0);
                end
            endcase
        end
    end

    // Stall is seen by upstream in the same cycle the op is presented.
    assign stallC = !rst && (((state == IDLE) && memOp) ||
                             ((state == WAIT) && (cnt != LAST_CNT)));
`else
    logic unusedWaitCfg;
    assign unusedWaitCfg = ^CNT_W'(WAIT_CYCLES);
    assign stallC        = 1'b0;
`endif

    assign complete = !rst && !stallC;
    assign memWe    = complete && MemWriteM;
    assign StallM   = stallC;

    data_memory #(
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W)
    ) u_dmem (
        .clk (clk),
        .we  (memWe),
        .addr(wordAddr),
        .wd  (WriteDataM),
        .rd  (readData)
    );

    // Writeback register: full load on completion, control bubble otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            wb <= '0;
        end else if (complete) begin
            wb.regWrite  <= RegWriteM;
            wb.resultSrc <= ResultSrcM;
            wb.rd        <= RDM;
            wb.aluResult <= ALUResultM;
            wb.readData  <= readData;
            wb.pcPlus4   <= PCPlus4M;
        end else begin
            wb.regWrite  <= BUBBLE_REG_WRITE;
            wb.resultSrc <= BUBBLE_RESULT_SRC;
            wb.rd        <= BUBBLE_RD;
        end
    end

    assign RegWriteW  = wb.regWrite;
    assign ResultSrcW = wb.resultSrc;
    assign RDW        = wb.rd;
    assign ALUResultW = wb.aluResult;
    assign ReadDataW  = wb.readData;
    assign PCPlus4W   = wb.pcPlus4;
    assign ResultW    = wb.resultSrc ? wb.readData : wb.aluResult;

endmodule
